// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding command-to-APB master bridge.
// A command is latched in IDLE (or in the completing ACCESS cycle for
// back-to-back transfers), driven through SETUP and ACCESS, and one
// registered response pulse is produced per completed transfer.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS phases
// that see PREADY low for TIMEOUT_CYCLES consecutive cycles.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [2:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY,
  input  logic       PSLVERR,
  input  logic [7:0] PRDATA,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rsp_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       psel_q, psel_d;
  logic       penable_q, penable_d;
  logic       pwrite_q, pwrite_d;
  logic [2:0] paddr_q, paddr_d;
  logic [7:0] pwdata_q, pwdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic       rsp_err_q, rsp_err_d;
  logic       accept;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
  logic       rsp_timeout_q, rsp_timeout_d;
`endif

  // Ready only when the FSM can take a new command this cycle; masked in reset.
  assign cmd_ready = !PRESET &&
                     ((state_q == ST_IDLE) || ((state_q == ST_ACCESS) && PREADY));
  assign accept    = cmd_valid && cmd_ready;

  // Next-state and next-output logic; APB strobes follow directly from the next state.
  always_comb begin
    state_d     = state_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    rsp_timeout_d = rsp_timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
          tmo_cnt_d = 8'd0;
`endif
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          // Completion: capture slave status; write responses carry no data.
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 8'h00 : PRDATA;
          rsp_err_d   = PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_timeout_d = 1'b0;
`endif
          if (accept) begin
            state_d  = ST_SETUP;
            pwrite_d = cmd_write;
            paddr_d  = cmd_addr;
            pwdata_d = cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt_d = 8'd0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else begin
          // Wait state: abort once the limit of consecutive low-PREADY cycles is hit.
          tmo_cnt_d = tmo_cnt_q + 8'd1;
          if (tmo_cnt_d == TMO_LIM) begin
            state_d       = ST_IDLE;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = 8'h00;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    psel_d    = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  // State and registered outputs; reset clears everything and drops any pending response.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 3'd0;
      pwdata_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= 8'd0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: the bench plays both the command requester
// and the APB slave, and predicts every output from transfer-level rules.
module tb_apb_master_bridge;

  localparam int TMO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam int MAXW = 3;
`else
  localparam int MAXW = 6;
`endif

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [2:0] PADDR;
  logic [7:0] PWDATA;
  logic       PREADY, PSLVERR;
  logic [7:0] PRDATA;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err, rsp_timeout;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;
  int exp_rsp = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout)
  );

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) if (rsp_valid === 1'b1) rsp_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog obs=running exp=finished");
    $fatal(1, "watchdog");
  end

  // Reference rule: reads return slave data, writes return zero.
  function automatic logic [7:0] model_rdata(input bit w, input logic [7:0] rd);
    return w ? 8'h00 : rd;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Present a command while the bridge is idle; leaves the bench in the SETUP cycle.
  task automatic issue(input bit w, input logic [2:0] a, input logic [7:0] d);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    #1;
    chk("idle_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Slave side of one transfer starting in SETUP; optionally chains the next command.
  task automatic apb_phase(input bit w, input logic [2:0] a, input logic [7:0] d,
                           input int waits, input logic [7:0] rd, input bit err,
                           input bit chain, input bit nw, input logic [2:0] na,
                           input logic [7:0] nd);
    chk("setup_psel", PSEL, 1);
    chk("setup_penable", PENABLE, 0);
    chk("setup_paddr", PADDR, a);
    chk("setup_pwrite", PWRITE, w);
    chk("setup_pwdata", PWDATA, d);
    cmd_valid = 1'b1; cmd_write = ~w; cmd_addr = ~a; cmd_wdata = ~d;
    PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'b1; PRDATA = 8'($urandom);
    #1;
    chk("setup_ready", cmd_ready, 0);
    step();
    for (int i = 0; i < waits; i++) begin
      PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 8'($urandom);
      #1;
      chk("wait_psel", PSEL, 1);
      chk("wait_penable", PENABLE, 1);
      chk("wait_paddr", PADDR, a);
      chk("wait_pwdata", PWDATA, d);
      chk("wait_ready", cmd_ready, 0);
      chk("wait_rsp", rsp_valid, 0);
      step();
    end
    PREADY = 1'b1; PRDATA = rd; PSLVERR = err;
    cmd_valid = chain; cmd_write = nw; cmd_addr = na; cmd_wdata = nd;
    #1;
    chk("done_penable", PENABLE, 1);
    chk("done_pwrite", PWRITE, w);
    chk("done_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
    exp_rsp++;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, model_rdata(w, rd));
    chk("rsp_err", rsp_err, err);
    chk("rsp_timeout", rsp_timeout, 0);
    chk("after_psel", PSEL, chain);
    chk("after_penable", PENABLE, 0);
    chk("after_paddr", PADDR, chain ? na : a);
    chk("after_pwdata", PWDATA, chain ? nd : d);
  endtask

  initial begin
    logic [7:0] d1, d2, rd;
    bit cw, nw, chain;
    logic [2:0] ca, na;
    logic [7:0] cd, nd;
    int acc;

    PRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 3'd0; cmd_wdata = 8'h00;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 8'h00;

    // Reset state.
    repeat (3) step();
    cmd_valid = 1'b1;
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    cmd_valid = 1'b0;
    PRESET = 1'b0;
    step();

    // Single write with zero wait states.
    issue(1'b1, 3'b101, 8'hA5);
    apb_phase(1'b1, 3'b101, 8'hA5, 0, 8'h77, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    chk("wr_rsp_once", rsp_valid, 0);
    chk("wr_idle_psel", PSEL, 0);

    // Read with three wait states.
    issue(1'b0, 3'b000, 8'h3C);
    apb_phase(1'b0, 3'b000, 8'h3C, 3, 8'h5C, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step();

    // Back-to-back writes with no idle gap.
    d1 = 8'($urandom); d2 = 8'($urandom);
    issue(1'b1, 3'd0, d1);
    apb_phase(1'b1, 3'd0, d1, 1, 8'hEE, 1'b0, 1'b1, 1'b1, 3'd2, d2);
    apb_phase(1'b1, 3'd2, d2, 0, 8'hEE, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step();

    // Slave error on read; PSLVERR during waits is ignored.
    issue(1'b0, 3'd4, 8'h00);
    apb_phase(1'b0, 3'd4, 8'h00, 2, 8'h91, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
    step();
    issue(1'b0, 3'd1, 8'h00);
    apb_phase(1'b0, 3'd1, 8'h00, 2, 8'h19, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step();

`ifdef APB_MASTER_TIMEOUT_EN
    // PREADY stuck low: abort after TMO access cycles with a timeout response.
    issue(1'b0, 3'd6, 8'h00);
    PREADY = 1'b0;
    step();
    acc = 0;
    while (PENABLE === 1'b1 && acc < 40) begin
      PRDATA = 8'($urandom);
      acc++;
      step();
    end
    exp_rsp++;
    chk("tmo_cycles", acc, TMO);
    chk("tmo_psel", PSEL, 0);
    chk("tmo_rsp", rsp_valid, 1);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_flag", rsp_timeout, 1);
    chk("tmo_rdata", rsp_rdata, 0);
    step();
    chk("tmo_rsp_once", rsp_valid, 0);
`else
    // PREADY low for 25 cycles: the bridge keeps waiting.
    issue(1'b0, 3'd6, 8'h00);
    apb_phase(1'b0, 3'd6, 8'h00, 25, 8'hC3, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step();
`endif

    // Reset in ACCESS while a completion is due: no response, clean restart.
    issue(1'b0, 3'd3, 8'h00);
    PREADY = 1'b0;
    step();
    step();
    PRESET = 1'b1; PREADY = 1'b1; PRDATA = 8'hAB; cmd_valid = 1'b1;
    #1;
    chk("midrst_ready", cmd_ready, 0);
    step();
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_paddr", PADDR, 0);
    chk("midrst_rsp", rsp_valid, 0);
    chk("midrst_rdata", rsp_rdata, 0);
    PRESET = 1'b0; PREADY = 1'b0; cmd_valid = 1'b0;
    #1;
    chk("postrst_ready", cmd_ready, 1);
    step();
    chk("postrst_rsp", rsp_valid, 0);
    issue(1'b1, 3'd7, 8'h42);
    apb_phase(1'b1, 3'd7, 8'h42, 1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step();

    // Random transfers with random chaining, waits, data and errors.
    cw = 1'($urandom); ca = 3'($urandom); cd = 8'($urandom);
    issue(cw, ca, cd);
    for (int k = 0; k < 24; k++) begin
      nw = 1'($urandom); na = 3'($urandom); nd = 8'($urandom);
      chain = (k != 23) && 1'($urandom);
      rd = 8'($urandom);
      apb_phase(cw, ca, cd, int'($urandom_range(0, MAXW)), rd, 1'($urandom),
                chain, nw, na, nd);
      if (k != 23 && !chain) begin
        step();
        chk("rnd_rsp_once", rsp_valid, 0);
        issue(nw, na, nd);
      end
      cw = nw; ca = na; cd = nd;
    end
    step();
    step();
    chk("rsp_count", rsp_cnt, exp_rsp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
